seq_restoring_divider: RTL and testbench
========================================

SEQ_RESTORING_DIVIDER -- requirements
Module: seq_restoring_divider

Interface
REQ-001 Parameter DVDND_W, default 24, dividend and quotient width (>=2).
REQ-002 Parameter DVSR_W, default 16, divisor and remainder width (2..DVDND_W).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operands valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 dvdnd  input  DVDND_W  dividend.
REQ-008 dvisor  input  DVSR_W  divisor.
REQ-009 signed_mode  input  1  1 means two's-complement operands; 0 means unsigned.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 q  output  DVDND_W  quotient.
REQ-013 r  output  DVSR_W  remainder.
REQ-014 dbz  output  1  divisor was zero.
REQ-015 ovf  output  1  signed quotient overflow.

Function
REQ-016 The block SHALL have three states: IDLE, BUSY and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 When in_valid=1 in IDLE on an edge, the block SHALL capture dvdnd, dvisor and signed_mode, and SHALL enter BUSY with iteration count 0.
REQ-019 In BUSY, each edge SHALL perform one restoring step: shift the next dividend magnitude bit (MSB first) into a DVSR_W+1-bit partial remainder; subtract the divisor magnitude; on no borrow, keep the difference and set the quotient bit; otherwise restore and clear the bit.
REQ-020 After the DVDND_W-th step edge, the block SHALL enter DONE, so out_valid rises exactly DVDND_W edges after the accept edge.
REQ-021 In signed mode, operand magnitudes SHALL be divided; q SHALL be negated when operand signs differ; r SHALL take the sign of the dividend (truncating division).
REQ-022 In unsigned mode, q*dvisor + r SHALL equal dvdnd, with r < dvisor.
REQ-023 For divisor 0, the block SHALL run the full latency, produce q = all ones and r = low DVSR_W bits of the dividend magnitude, and set dbz=1; in signed mode, the sign fix-up of REQ-021 SHALL NOT be applied.
REQ-024 For signed dividend = most-negative and divisor = -1, the block SHALL produce q = most-negative (wrapped), r=0 and ovf=1.
REQ-025 In DONE, q, r, dbz and ovf SHALL be held stable until out_ready=1 on an edge, which SHALL return the block to IDLE.
REQ-026 in_valid SHALL be ignored in BUSY and DONE; there SHALL be no same-cycle accept on the DONE to IDLE edge.
REQ-027 dbz and ovf SHALL be 0 whenever the respective condition is absent.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, with in_ready=1, out_valid=0, and q, r, dbz and ovf all 0, including mid-BUSY or mid-DONE; the partial result SHALL be discarded.
REQ-029 After rst is released, the first accept SHALL behave as REQ-018.

Structure
REQ-030 A shared package div_pkg SHALL hold the state enum (IDLE/BUSY/DONE) and the default width constants.
REQ-031 One combinational sub-module, div_step, SHALL implement a single shift-subtract-restore step (parametrised by DVSR_W), instantiated once and reused every cycle.
REQ-032 The iteration counter SHALL be $clog2(DVDND_W+1) bits wide.

Verification
REQ-033 Unsigned: dvdnd=1000000, dvisor=7 -> q=142857, r=1, dbz=0; out_valid 24 edges after accept.
REQ-034 Signed: dvdnd=-100, dvisor=7 -> q=-14 (0xFFFFF2), r=-2 (0xFFFE); dvdnd=100, dvisor=-7 -> q=-14, r=2.
REQ-035 Divide by zero: dvdnd=0x00ABCD, dvisor=0, unsigned -> q=0xFFFFFF, r=0xABCD, dbz=1.
REQ-036 Signed overflow: dvdnd=0x800000, dvisor=0xFFFF -> q=0x800000, r=0, ovf=1.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0; assert in_valid during BUSY -> ignored.
REQ-038 Reset mid-operation: assert rst at step 10 -> IDLE and zero outputs at once; a new 1000000/7 afterwards -> q=142857, r=1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states and default widths.
package div_pkg;

  localparam int DVDND_W_DEF = 24;
  localparam int DVSR_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One shift-subtract-restore step of a restoring divider (purely combinational).
module div_step #(
  parameter int DVSR_W = 16
) (
  input  logic [DVSR_W:0]   rem_i,
  input  logic              bit_i,
  input  logic [DVSR_W-1:0] dvsr_i,
  output logic [DVSR_W:0]   rem_o,
  output logic              qbit_o
);

  logic [DVSR_W:0] shifted;
  logic [DVSR_W:0] diffLow;
  logic            borrow;

  assign shifted = {rem_i[DVSR_W-1:0], bit_i};
  assign {borrow, diffLow} = {1'b0, shifted} - {2'b00, dvsr_i};

  // A set top bit in the incoming remainder would make the shifted value exceed any divisor.
  assign qbit_o = ~borrow | rem_i[DVSR_W];
  assign rem_o  = qbit_o ? diffLow : shifted;

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock, signed/unsigned, with
// divide-by-zero and signed-overflow flags and a valid/ready handshake on both sides.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int DVDND_W = DVDND_W_DEF,
  parameter int DVSR_W  = DVSR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DVDND_W-1:0] dvdnd,
  input  logic [DVSR_W-1:0]  dvisor,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DVDND_W-1:0] q,
  output logic [DVSR_W-1:0]  r,
  output logic               dbz,
  output logic               ovf
);

  localparam int CNT_W = $clog2(DVDND_W + 1);
  localparam logic [DVDND_W-1:0] DVDND_MIN = {1'b1, {(DVDND_W-1){1'b0}}};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DVDND_W-1:0] work_q, work_d;
  logic [DVSR_W:0]    rem_q, rem_d;
  logic [DVSR_W-1:0]  dvsr_q, dvsr_d;
  logic               negDvdnd_q, negDvdnd_d;
  logic               negDvsr_q, negDvsr_d;
  logic               dbzPend_q, dbzPend_d;
  logic               ovfPend_q, ovfPend_d;
  logic [DVDND_W-1:0] q_q, q_d;
  logic [DVSR_W-1:0]  r_q, r_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;

  logic [DVSR_W:0]    stepRem;
  logic               stepQbit;
  logic [DVDND_W-1:0] qMag;
  logic [DVSR_W-1:0]  rMag;
  logic               dvdndNeg;
  logic               dvsrNeg;

  // The dividend register shifts its MSB into the step and collects quotient bits at the LSB.
  div_step #(.DVSR_W(DVSR_W)) uStep (
    .rem_i  (rem_q),
    .bit_i  (work_q[DVDND_W-1]),
    .dvsr_i (dvsr_q),
    .rem_o  (stepRem),
    .qbit_o (stepQbit)
  );

  assign dvdndNeg = signed_mode & dvdnd[DVDND_W-1];
  assign dvsrNeg  = signed_mode & dvisor[DVSR_W-1];
  assign qMag     = {work_q[DVDND_W-2:0], stepQbit};
  assign rMag     = stepRem[DVSR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      negDvdnd_q <= 1'b0;
      negDvsr_q  <= 1'b0;
      dbzPend_q  <= 1'b0;
      ovfPend_q  <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      rem_q      <= rem_d;
      dvsr_q     <= dvsr_d;
      negDvdnd_q <= negDvdnd_d;
      negDvsr_q  <= negDvsr_d;
      dbzPend_q  <= dbzPend_d;
      ovfPend_q  <= ovfPend_d;
      q_q        <= q_d;
      r_q        <= r_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    rem_d      = rem_q;
    dvsr_d     = dvsr_q;
    negDvdnd_d = negDvdnd_q;
    negDvsr_d  = negDvsr_q;
    dbzPend_d  = dbzPend_q;
    ovfPend_d  = ovfPend_q;
    q_d        = q_q;
    r_d        = r_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = BUSY;
          cnt_d      = '0;
          work_d     = dvdndNeg ? -dvdnd : dvdnd;
          dvsr_d     = dvsrNeg ? -dvisor : dvisor;
          rem_d      = '0;
          negDvdnd_d = dvdndNeg;
          negDvsr_d  = dvsrNeg;
          dbzPend_d  = (dvisor == '0);
          ovfPend_d  = signed_mode && (dvdnd == DVDND_MIN) && (&dvisor);
          q_d        = '0;
          r_d        = '0;
          dbz_d      = 1'b0;
          ovf_d      = 1'b0;
        end
      end
      BUSY: begin
        work_d = qMag;
        rem_d  = stepRem;
        cnt_d  = cnt_q + CNT_W'(1);
        // Divide-by-zero results skip the sign fix-up and keep the raw magnitudes.
        if (cnt_q == CNT_W'(DVDND_W - 1)) begin
          state_d = DONE;
          if (dbzPend_q) begin
            q_d   = '1;
            r_d   = rMag;
            dbz_d = 1'b1;
            ovf_d = 1'b0;
          end else begin
            q_d   = (negDvdnd_q ^ negDvsr_q) ? -qMag : qMag;
            r_d   = negDvdnd_q ? -rMag : rMag;
            dbz_d = 1'b0;
            ovf_d = ovfPend_q;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign q         = q_q;
  assign r         = r_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed vector table, handshake/reset
// corner sequences, and randomized operands against an arithmetic reference model.
module tb_seq_restoring_divider;

  localparam int AW = 24;
  localparam int BW = 16;

  typedef struct {
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          sm;
    logic [AW-1:0] eq;
    logic [BW-1:0] er;
    logic          edbz;
    logic          eovf;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] dvdnd;
  logic [BW-1:0] dvisor;
  logic          signed_mode;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] q;
  logic [BW-1:0] r;
  logic          dbz;
  logic          ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_restoring_divider #(.DVDND_W(AW), .DVSR_W(BW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dvdnd       (dvdnd),
    .dvisor      (dvisor),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .q           (q),
    .r           (r),
    .dbz         (dbz),
    .ovf         (ovf)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Truncating division from plain integer arithmetic, plus the zero-divisor and overflow rules.
  function automatic void refModel(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic sm,
                                   output logic [AW-1:0] eq, output logic [BW-1:0] er,
                                   output logic edbz, output logic eovf);
    longint sa, sb;
    logic [AW-1:0] magA;
    eq = '0; er = '0; edbz = 1'b0; eovf = 1'b0;
    if (b == '0) begin
      magA = (sm && a[AW-1]) ? -a : a;
      eq   = '1;
      er   = magA[BW-1:0];
      edbz = 1'b1;
    end else if (sm) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sa == -(longint'(1) << (AW - 1)) && sb == -1) begin
        eq   = {1'b1, {(AW-1){1'b0}}};
        er   = '0;
        eovf = 1'b1;
      end else begin
        eq = AW'(sa / sb);
        er = BW'(sa % sb);
      end
    end else begin
      eq = AW'(longint'(a) / longint'(b));
      er = BW'(longint'(a) % longint'(b));
    end
  endfunction

  task automatic startOp(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic sm);
    @(negedge clk);
    checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
    dvdnd       = a;
    dvisor      = b;
    signed_mode = sm;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Runs one operation to DONE; optionally keeps in_valid high with junk operands while busy.
  task automatic applyStimulus(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic sm,
                               input logic pokeBusy);
    int lat;
    startOp(a, b, sm);
    if (pokeBusy) begin
      in_valid    = 1'b1;
      dvdnd       = AW'($urandom);
      dvisor      = BW'($urandom);
      signed_mode = ~sm;
    end
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat < AW) checkOutput("in_ready_low_busy", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    checkOutput("latency", 32'(lat), 32'(AW));
  endtask

  task automatic releaseResult();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("idle_after_release", 32'(in_ready), 32'd1);
    checkOutput("out_valid_after_release", 32'(out_valid), 32'd0);
  endtask

  task automatic checkResult(input string tag, input logic [AW-1:0] eq, input logic [BW-1:0] er,
                             input logic edbz, input logic eovf);
    checkOutput({tag, "_q"}, 32'(q), 32'(eq));
    checkOutput({tag, "_r"}, 32'(r), 32'(er));
    checkOutput({tag, "_dbz"}, 32'(dbz), 32'(edbz));
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'(eovf));
  endtask

  task automatic checkZeroIdle(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkResult(tag, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    vec_t          vecs[8];
    logic [AW-1:0] eq, holdQ;
    logic [BW-1:0] er, holdR;
    logic          edbz, eovf;
    logic [AW-1:0] ra;
    logic [BW-1:0] rb;
    logic          rsm;
    int            pick;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dvdnd = '0; dvisor = '0; signed_mode = 1'b0;

    vecs[0] = '{24'd1000000, 16'd7,    1'b0, 24'd142857, 16'd1,    1'b0, 1'b0};
    vecs[1] = '{24'hFFFF9C,  16'd7,    1'b1, 24'hFFFFF2, 16'hFFFE, 1'b0, 1'b0};
    vecs[2] = '{24'd100,     16'hFFF9, 1'b1, 24'hFFFFF2, 16'd2,    1'b0, 1'b0};
    vecs[3] = '{24'h00ABCD,  16'd0,    1'b0, 24'hFFFFFF, 16'hABCD, 1'b1, 1'b0};
    vecs[4] = '{24'h800000,  16'hFFFF, 1'b1, 24'h800000, 16'd0,    1'b0, 1'b1};
    vecs[5] = '{24'hFFFF9C,  16'd0,    1'b1, 24'hFFFFFF, 16'h0064, 1'b1, 1'b0};
    vecs[6] = '{24'hFFFFFF,  16'hFFFF, 1'b0, 24'h000100, 16'h00FF, 1'b0, 1'b0};
    vecs[7] = '{24'h800000,  16'd1,    1'b1, 24'h800000, 16'd0,    1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    checkZeroIdle("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sm, 1'b0);
      checkResult($sformatf("vec%0d", i), vecs[i].eq, vecs[i].er, vecs[i].edbz, vecs[i].eovf);
      releaseResult();
    end

    // Backpressure in DONE with in_valid asserted, then no accept on the release edge.
    applyStimulus(24'hFFFF9C, 16'd7, 1'b1, 1'b1);
    holdQ = q;
    holdR = r;
    checkOutput("bp_first_q", 32'(holdQ), 32'h00FFFFF2);
    @(negedge clk);
    in_valid = 1'b1;
    dvdnd    = 24'd5;
    dvisor   = 16'd3;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_hold_q", 32'(q), 32'(holdQ));
      checkOutput("bp_hold_r", 32'(r), 32'(holdR));
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("no_same_cycle_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b0;

    // Reset partway through BUSY, then a clean operation.
    startOp(24'd1000000, 16'd7, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkZeroIdle("rst_busy");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(24'd1000000, 16'd7, 1'b0, 1'b0);
    checkResult("after_rst", 24'd142857, 16'd1, 1'b0, 1'b0);
    releaseResult();

    // Reset while a divide-by-zero result is being held.
    applyStimulus(24'h00ABCD, 16'd0, 1'b0, 1'b0);
    checkOutput("pre_rst_dbz", 32'(dbz), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkZeroIdle("rst_done");
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 150; n++) begin
      ra   = AW'($urandom);
      rsm  = 1'($urandom);
      pick = $urandom_range(0, 9);
      if (pick == 0) rb = '0;
      else if (pick == 1) rb = '1;
      else if (pick == 2) rb = BW'($urandom_range(1, 15));
      else rb = BW'($urandom);
      if ($urandom_range(0, 9) == 0) ra = 24'h800000;
      refModel(ra, rb, rsm, eq, er, edbz, eovf);
      applyStimulus(ra, rb, rsm, 1'($urandom));
      checkResult("rand", eq, er, edbz, eovf);
      releaseResult();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
